// File: rtl/signed_product_accumulator_pkg.sv
// Shared definitions for the signed product accumulator: width helper,
// default geometry and the output-buffer state encoding.
package signed_product_accumulator_pkg;

    // Ceiling log2 as a constant function; clog2(1) = 0, clog2(8) = 3.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int WIDTH_DEF = 12;
    localparam int LEN_DEF   = 8;
    localparam int ACC_W_DEF = 2 * WIDTH_DEF + clog2(LEN_DEF);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/signed_product_accumulator.sv
// Sums LEN consecutive signed products into a full-precision result held in a
// one-deep valid/ready output buffer; only the final term of a vector can stall.
module signed_product_accumulator
    import signed_product_accumulator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN   = LEN_DEF,
    parameter int ACC_W = 2 * WIDTH + clog2(LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int EXT_W  = ACC_W - PROD_W;
    localparam int CNT_W  = (clog2(LEN) < 1) ? 1 : clog2(LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    buf_state_t       state_q, state_d;

    logic             last_term;
    logic             accept;
    logic             final_accept;
    logic             release_evt;
    logic [ACC_W-1:0] prod_ext;

    assign last_term   = (cnt_q == LAST_CNT);
    assign out_valid   = (state_q == BUF_FULL);
    assign out_sum     = sum_q;
    assign release_evt = out_valid && out_ready;
    // Stall only a final term that has nowhere to go; out_ready frees it this cycle.
    assign in_ready    = !(last_term && out_valid && !out_ready);
    // clr wins over a simultaneous product: the product is dropped.
    assign accept      = in_valid && in_ready && !clr;
    assign final_accept = accept && last_term;
    assign prod_ext    = {{EXT_W{in_prod[PROD_W-1]}}, in_prod};

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        sum_d = sum_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (last_term) begin
                sum_d = acc_q + prod_ext;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_q + prod_ext;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: if (final_accept) state_d = BUF_FULL;
            BUF_FULL:  if (release_evt && !final_accept) state_d = BUF_EMPTY;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            state_q <= BUF_EMPTY;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_signed_product_accumulator.sv
// Directed bench for signed_product_accumulator with hand-computed sums.
module tb_signed_product_accumulator;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_prod;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] out_sum;

    int checks;
    int failures;

    signed_product_accumulator dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_prod  (in_prod),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one product across one clock edge; leaves time at edge+1.
    task automatic push(input logic [23:0] p);
        in_valid = 1'b1;
        in_prod  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_sum", $signed(out_sum), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic sum of eight ones, single-cycle out_valid
        for (int i = 0; i < 7; i++) begin
            push(24'd1);
            check_eq("basic_no_early_valid", out_valid, 0);
        end
        push(24'd1);
        check_eq("basic_valid", out_valid, 1);
        check_eq("basic_sum", $signed(out_sum), 8);
        idle_cycle();
        check_eq("basic_valid_one_cycle", out_valid, 0);

        // Extremes
        for (int i = 0; i < 8; i++) push(24'h400000);
        check_eq("max_pos_valid", out_valid, 1);
        check_eq("max_pos_sum", $signed(out_sum), 33554432);
        for (int i = 0; i < 8; i++) push(24'(-4192256));
        check_eq("max_neg_valid", out_valid, 1);
        check_eq("max_neg_sum", $signed(out_sum), -33538048);
        idle_cycle();

        // Backpressure: 16 products of 3 with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(24'd3);
        check_eq("bp_first_valid", out_valid, 1);
        check_eq("bp_first_sum", $signed(out_sum), 24);
        for (int i = 0; i < 7; i++) begin
            check_eq("bp_ready_mid_vector", in_ready, 1);
            push(24'd3);
            check_eq("bp_sum_stable", $signed(out_sum), 24);
        end
        in_valid = 1'b1;
        in_prod  = 24'd3;
        #1;
        check_eq("bp_ready_drops_on_last", in_ready, 0);
        @(posedge clk);
        #1;
        check_eq("bp_stalled_valid", out_valid, 1);
        check_eq("bp_stalled_sum", $signed(out_sum), 24);
        check_eq("bp_still_stalled", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check_eq("bp_ready_comb_from_out_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check_eq("bp_second_valid", out_valid, 1);
        check_eq("bp_second_sum", $signed(out_sum), 24);
        idle_cycle();
        check_eq("bp_drained", out_valid, 0);

        // Simultaneous release and final-term accept with distinct sums
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(24'd5);
        check_eq("sim_first_sum", $signed(out_sum), 40);
        for (int i = 0; i < 7; i++) push(24'd7);
        out_ready = 1'b1;
        push(24'd7);
        check_eq("sim_valid_no_bubble", out_valid, 1);
        check_eq("sim_new_sum", $signed(out_sum), 56);
        idle_cycle();
        check_eq("sim_released", out_valid, 0);

        // Clear discards a partial vector and a same-cycle product
        for (int i = 0; i < 3; i++) push(24'd100);
        clr = 1'b1;
        push(24'd100);
        clr = 1'b0;
        for (int i = 0; i < 7; i++) push(24'd2);
        check_eq("clr_no_early_valid", out_valid, 0);
        push(24'd2);
        check_eq("clr_valid", out_valid, 1);
        check_eq("clr_sum", $signed(out_sum), 16);
        idle_cycle();

        // Clear leaves a held result intact
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(24'd9);
        clr = 1'b1;
        push(24'd50);
        clr = 1'b0;
        check_eq("clr_keeps_valid", out_valid, 1);
        check_eq("clr_keeps_sum", $signed(out_sum), 72);

        // Asynchronous reset mid-vector with a held result
        for (int i = 0; i < 5; i++) push(24'd1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_out_sum", $signed(out_sum), 0);
        check_eq("arst_in_ready", in_ready, 1);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) push(24'(-1));
        check_eq("post_rst_no_early_valid", out_valid, 0);
        push(24'(-1));
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_sum", $signed(out_sum), -8);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
